// File: rtl/lsq_pkg.sv
// Shared LSQ types: arbiter FSM states, grant encoding, sequence tags and opcodes.
package lsq_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} arb_state_e;

   typedef enum logic [1:0] {GNT_NONE, GNT_LD, GNT_ST} grant_e;

   localparam int unsigned SEQ_TAG_W = 4;
   typedef logic [SEQ_TAG_W-1:0] seq_t;

   localparam logic [3:0] LOAD  = 4'b0000;
   localparam logic [3:0] STORE = 4'b0001;

endpackage

// File: rtl/lsq_mem_arbiter_if.sv
// LSQ-head request/response and memory-port signals of the LSQ memory arbiter.
interface lsq_mem_arbiter_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned MEM_AW = 10,
   parameter int unsigned SEQ_W  = 4
);

   logic              ld_valid;
   logic              ld_ready;
   logic [WIDTH-1:0]  ld_addr;
   logic [SEQ_W-1:0]  ld_seq;
   logic              st_valid;
   logic              st_ready;
   logic [WIDTH-1:0]  st_addr;
   logic [WIDTH-1:0]  st_data;
   logic [SEQ_W-1:0]  st_seq;
   logic              ld_rsp_valid;
   logic [WIDTH-1:0]  ld_rsp_data;
   logic              mem_req;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_wdata;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [WIDTH-1:0]  mem_rdata;
   logic              busy;

   // Queue heads and memory model side.
   modport master (
      output ld_valid, ld_addr, ld_seq, st_valid, st_addr, st_data, st_seq,
             mem_ready, mem_rvalid, mem_rdata,
      input  ld_ready, st_ready, ld_rsp_valid, ld_rsp_data, mem_req, mem_we, mem_addr,
             mem_wdata, busy
   );

   // Arbiter side.
   modport slave (
      input  ld_valid, ld_addr, ld_seq, st_valid, st_addr, st_data, st_seq,
             mem_ready, mem_rvalid, mem_rdata,
      output ld_ready, st_ready, ld_rsp_valid, ld_rsp_data, mem_req, mem_we, mem_addr,
             mem_wdata, busy
   );

endinterface

// File: rtl/lsq_seq_older.sv
// Wrap-safe program-order compare: a_older when (a - b) mod 2^SEQ_W has its MSB set.
module lsq_seq_older #(
   parameter int unsigned SEQ_W = 4
) (
   input  logic [SEQ_W-1:0] a,
   input  logic [SEQ_W-1:0] b,
   output logic             a_older
);

   logic [SEQ_W-1:0] diff;

   assign diff    = a - b;
   assign a_older = diff[SEQ_W-1];

endmodule

// File: rtl/lsq_mem_arbiter.sv
// Single-port memory arbiter for LQ commit and SQ drain; one transaction in flight.
// Store aging (starvation counter) is built only when LSQ_ARB_AGING_EN is defined.
module lsq_mem_arbiter
   import lsq_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned MEM_AW       = 10,
   parameter int unsigned SEQ_W        = 4,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic              clk,
   input logic              rst,
   lsq_mem_arbiter_if.slave bus
);

   arb_state_e        state;
   grant_e            grant;
   logic              ld_older;
   logic              aged;
   logic              ld_ready;
   logic              st_ready;
   logic [3:0]        op_q;
   logic              mem_req_q;
   logic [MEM_AW-1:0] mem_addr_q;
   logic [WIDTH-1:0]  mem_wdata_q;
   logic              rsp_valid_q;
   logic [WIDTH-1:0]  rsp_data_q;
   logic              busy_q;

   lsq_seq_older #(
      .SEQ_W (SEQ_W)
   ) u_seq_older (
      .a       (bus.ld_seq),
      .b       (bus.st_seq),
      .a_older (ld_older)
   );

`ifdef LSQ_ARB_AGING_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (bus.st_valid && st_ready) begin
         starve_cnt <= '0;
      end else if (bus.st_valid && (starve_cnt != '1)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   assign aged = (starve_cnt >= STARVE_TH);
`else
   assign aged = 1'b0;
`endif

   // Same-address pairs keep program order; equal tags favour the store.
   always_comb begin
      grant = GNT_NONE;
      if (!rst && (state == IDLE)) begin
         if (bus.ld_valid && !bus.st_valid) begin
            grant = GNT_LD;
         end else if (!bus.ld_valid && bus.st_valid) begin
            grant = GNT_ST;
         end else if (bus.ld_valid && bus.st_valid) begin
            if (bus.ld_addr == bus.st_addr) begin
               grant = ld_older ? GNT_LD : GNT_ST;
            end else if (aged) begin
               grant = GNT_ST;
            end else begin
               grant = GNT_LD;
            end
         end
      end
   end

   assign ld_ready = (grant == GNT_LD);
   assign st_ready = (grant == GNT_ST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= LOAD;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant != GNT_NONE) begin
                  state     <= ISSUE;
                  busy_q    <= 1'b1;
                  mem_req_q <= 1'b1;
                  if (grant == GNT_ST) begin
                     op_q        <= STORE;
                     mem_addr_q  <= bus.st_addr[MEM_AW-1:0];
                     mem_wdata_q <= bus.st_data;
                  end else begin
                     op_q        <= LOAD;
                     mem_addr_q  <= bus.ld_addr[MEM_AW-1:0];
                     mem_wdata_q <= '0;
                  end
               end
            end
            ISSUE: begin
               if (bus.mem_ready) begin
                  mem_req_q <= 1'b0;
                  if (op_q == STORE) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     state <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (bus.mem_rvalid) begin
                  rsp_data_q  <= bus.mem_rdata;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ld_ready     = ld_ready;
   assign bus.st_ready     = st_ready;
   assign bus.ld_rsp_valid = rsp_valid_q;
   assign bus.ld_rsp_data  = rsp_data_q;
   assign bus.mem_req      = mem_req_q;
   assign bus.mem_we       = (op_q == STORE);
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Self-checking bench for lsq_mem_arbiter: directed cases then random traffic against a
// transaction-level model (arbitration rules, store wait counter, memory contents).
module tb_lsq_mem_arbiter;

   localparam int WIDTH        = 32;
   localparam int MEM_AW       = 10;
   localparam int SEQ_W        = 4;
   localparam int STARVE_LIMIT = 4;
`ifdef LSQ_ARB_AGING_EN
   localparam int EXP_ST_IDX = 2;
`else
   localparam int EXP_ST_IDX = 0;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   lsq_mem_arbiter_if #(.WIDTH(WIDTH), .MEM_AW(MEM_AW), .SEQ_W(SEQ_W)) bus ();

   lsq_mem_arbiter #(
      .WIDTH        (WIDTH),
      .MEM_AW       (MEM_AW),
      .SEQ_W        (SEQ_W),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int starve = 0;
   logic [31:0] mem_model [int];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit tag_older(input int a, input int b);
      int m;
      m = 1 << SEQ_W;
      return ((((a - b) % m) + m) % m) >= (m / 2);
   endfunction

   // 0 = nothing, 1 = load, 2 = store
   function automatic int exp_grant();
      if (bus.ld_valid && !bus.st_valid) return 1;
      if (!bus.ld_valid && bus.st_valid) return 2;
      if (bus.ld_valid && bus.st_valid) begin
         if (bus.ld_addr == bus.st_addr) return tag_older(bus.ld_seq, bus.st_seq) ? 1 : 2;
`ifdef LSQ_ARB_AGING_EN
         if (starve >= STARVE_LIMIT) return 2;
`endif
         return 1;
      end
      return 0;
   endfunction

   // Count of cycles the store head has waited; any value at or above the limit acts alike.
   function automatic void note_cycle(input int g);
      if (g == 2) starve = 0;
      else if (bus.st_valid && starve < STARVE_LIMIT) starve++;
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] addr);
      int idx;
      idx = int'(addr[MEM_AW-1:0]);
      return mem_model.exists(idx) ? mem_model[idx] : 32'h0;
   endfunction

   task automatic do_reset();
      rst            = 1'b1;
      bus.ld_valid   = 1'b0;
      bus.st_valid   = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      tick();
      tick();
      rst    = 1'b0;
      starve = 0;
   endtask

   // Entered in an idle cycle with inputs settled; returns at the next idle cycle.
   task automatic run_txn(input int stall, input int lat);
      int          g;
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      g = exp_grant();
      check("ld_ready", bus.ld_ready, 32'(g == 1));
      check("st_ready", bus.st_ready, 32'(g == 2));
      check("busy_idle", bus.busy, 0);
      note_cycle(g);
      if (g == 0) begin
         tick();
         return;
      end
      we = (g == 2);
      a  = we ? bus.st_addr : bus.ld_addr;
      d  = bus.st_data;
      tick();
      if (we) bus.st_valid = 1'b0;
      else bus.ld_valid = 1'b0;
      for (int i = 0; i <= stall; i++) begin
         bus.mem_ready  = (i == stall);
         bus.mem_rvalid = 1'($urandom_range(0, 1));
         #1;
         check("mem_req", bus.mem_req, 1);
         check("mem_we", bus.mem_we, 32'(we));
         check("mem_addr", bus.mem_addr, 32'(a[MEM_AW-1:0]));
         if (we) check("mem_wdata", bus.mem_wdata, d);
         check("no_ready_issue", 32'(bus.ld_ready | bus.st_ready), 0);
         check("busy_issue", bus.busy, 1);
         note_cycle(0);
         tick();
      end
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (we) begin
         mem_model[int'(a[MEM_AW-1:0])] = d;
         return;
      end
      for (int i = 0; i < lat; i++) begin
         bus.mem_ready = 1'($urandom_range(0, 1));
         #1;
         check("rsp_wait", bus.ld_rsp_valid, 0);
         check("mem_req_wait", bus.mem_req, 0);
         check("busy_wait", bus.busy, 1);
         note_cycle(0);
         tick();
      end
      bus.mem_ready  = 1'b0;
      rd             = mem_read(a);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rd;
      #1;
      check("rsp_early", bus.ld_rsp_valid, 0);
      note_cycle(0);
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      #1;
      check("rsp_valid", bus.ld_rsp_valid, 1);
      check("rsp_data", bus.ld_rsp_data, rd);
      check("no_ready_resp", 32'(bus.ld_ready | bus.st_ready), 0);
      note_cycle(0);
      tick();
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 32'h40;
         1:       return 32'h44;
         2:       return 32'h1040;
         default: return $urandom & 32'h3fc;
      endcase
   endfunction

   initial begin
      int st_idx;
      bus.ld_valid   = 1'b0;
      bus.ld_addr    = '0;
      bus.ld_seq     = '0;
      bus.st_valid   = 1'b0;
      bus.st_addr    = '0;
      bus.st_data    = '0;
      bus.st_seq     = '0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;

      // Reset, with requests pending while it is asserted.
      rst          = 1'b1;
      bus.ld_valid = 1'b1;
      bus.st_valid = 1'b1;
      tick();
      tick();
      check("rst_ld_ready", bus.ld_ready, 0);
      check("rst_st_ready", bus.st_ready, 0);
      bus.ld_valid = 1'b0;
      bus.st_valid = 1'b0;
      #1;
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_rsp_valid", bus.ld_rsp_valid, 0);
      check("rst_rsp_data", bus.ld_rsp_data, 0);
      check("rst_busy", bus.busy, 0);
      rst    = 1'b0;
      starve = 0;
      tick();

      // Single store, then a load of the same location with 3-cycle read latency.
      bus.st_valid = 1'b1;
      bus.st_addr  = 32'h10;
      bus.st_data  = 32'hdead;
      bus.st_seq   = 4'd0;
      #1;
      run_txn(0, 0);
      check("store_idle_t2", bus.busy, 0);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'h10;
      bus.ld_seq   = 4'd1;
      #1;
      run_txn(0, 2);

      // Same-address ordering by tag, including wrap and equal tags.
      bus.ld_valid = 1'b1; bus.ld_addr = 32'h20; bus.ld_seq = 4'd5;
      bus.st_valid = 1'b1; bus.st_addr = 32'h20; bus.st_seq = 4'd3; bus.st_data = 32'h5a5a;
      #1;
      check("order_st_first", bus.st_ready, 1);
      run_txn(0, 0);
      #1;
      run_txn(0, 1);
      bus.ld_valid = 1'b1; bus.ld_seq = 4'd1;
      bus.st_valid = 1'b1; bus.st_seq = 4'd15; bus.st_data = 32'h1111;
      #1;
      check("wrap_st_older", bus.st_ready, 1);
      run_txn(1, 0);
      #1;
      run_txn(0, 0);
      bus.ld_valid = 1'b1; bus.ld_seq = 4'd15;
      bus.st_valid = 1'b1; bus.st_seq = 4'd1; bus.st_data = 32'h2222;
      #1;
      check("wrap_ld_older", bus.ld_ready, 1);
      run_txn(0, 0);
      #1;
      run_txn(0, 0);
      bus.ld_valid = 1'b1; bus.ld_seq = 4'd7;
      bus.st_valid = 1'b1; bus.st_seq = 4'd7; bus.st_data = 32'h3333;
      #1;
      check("equal_tag_st", bus.st_ready, 1);
      run_txn(0, 0);
      #1;
      run_txn(0, 0);

      // Addresses differ above MEM_AW, store older: plain load priority applies.
      do_reset();
      bus.ld_valid = 1'b1; bus.ld_addr = 32'h1020; bus.ld_seq = 4'd9;
      bus.st_valid = 1'b1; bus.st_addr = 32'h20;   bus.st_seq = 4'd3; bus.st_data = 32'h4444;
      #1;
      check("diff_addr_ld", bus.ld_ready, 1);
      run_txn(0, 0);
      #1;
      run_txn(0, 0);

      // Continuous load stream against one waiting store.
      do_reset();
      st_idx = 0;
      bus.st_valid = 1'b1; bus.st_addr = 32'h80; bus.st_seq = 4'd0; bus.st_data = 32'h8080;
      for (int i = 0; i < 6; i++) begin
         if (!bus.ld_valid) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 32'h100 + 32'(i * 4);
            bus.ld_seq   = 4'(i + 1);
         end
         #1;
         if (bus.st_ready && st_idx == 0) st_idx = i + 1;
         run_txn(0, 0);
      end
      check("aging_store_slot", 32'(st_idx), 32'(EXP_ST_IDX));
      do_reset();

      // Backpressure: five cycles of mem_ready low with both heads waiting.
      bus.ld_valid = 1'b1; bus.ld_addr = 32'h24; bus.ld_seq = 4'd2;
      bus.st_valid = 1'b1; bus.st_addr = 32'h28; bus.st_seq = 4'd3; bus.st_data = 32'h6666;
      #1;
      run_txn(5, 1);
      #1;
      run_txn(5, 0);

      // Reset while waiting for read data; a late rvalid must not produce a response.
      do_reset();
      bus.ld_valid = 1'b1; bus.ld_addr = 32'h30; bus.ld_seq = 4'd4;
      #1;
      check("rw_ld_ready", bus.ld_ready, 1);
      tick();
      bus.ld_valid  = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      starve = 0;
      check("rw_mem_req", bus.mem_req, 0);
      check("rw_busy", bus.busy, 0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1234;
      tick();
      bus.mem_rvalid = 1'b0;
      #1;
      check("rw_rsp_valid", bus.ld_rsp_valid, 0);
      check("rw_rsp_data", bus.ld_rsp_data, 0);
      check("rw_busy_after", bus.busy, 0);
      check("rw_mem_addr", bus.mem_addr, 0);
      check("rw_mem_we", bus.mem_we, 0);

      // Random traffic; payloads change only while their valid is low.
      for (int n = 0; n < 300; n++) begin
         if (!bus.ld_valid && $urandom_range(0, 2) != 0) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = pick_addr();
            bus.ld_seq   = 4'($urandom);
         end
         if (!bus.st_valid && $urandom_range(0, 2) != 0) begin
            bus.st_valid = 1'b1;
            bus.st_addr  = pick_addr();
            bus.st_data  = $urandom;
            bus.st_seq   = 4'($urandom);
         end
         #1;
         run_txn($urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
